// File: rtl/reg_dump_reader_pkg.sv
// Shared datapath definitions for the register-file dump reader.
// REG_ADDR_W / REG_DATA_W match the 32x32 register file (REG).
// dump_state_e is the walk FSM: IDLE -> READ -> SEND_A -> SEND_B -> (READ | DONE).
package reg_dump_reader_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned REG_COUNT  = 32;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    SEND_A,
    SEND_B,
    DONE
  } dump_state_e;

endpackage

// File: rtl/reg_dump_reader_if.sv
// Valid/ready dump stream carrying one (register index, contents) beat.
// master: dump_valid, dump_addr, dump_data out; dump_ready in.
// slave : the reverse, for the debug/trace consumer.
interface reg_dump_reader_if
  import reg_dump_reader_pkg::*;
#(
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter int unsigned DATA_W = REG_DATA_W
);

  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;

  modport master (
    output dump_valid,
    output dump_addr,
    output dump_data,
    input  dump_ready
  );

  modport slave (
    input  dump_valid,
    input  dump_addr,
    input  dump_data,
    output dump_ready
  );

endinterface

// File: rtl/reg_dump_reader.sv
// Register-file dump reader.
// Sits between the decode stage and REG's read-address inputs. While idle the
// core read addresses pass straight through; after a start pulse it walks all
// NUM_REGS registers two at a time through REG's combinational read ports and
// emits one (address, data) beat per register on the dump stream.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   start        single-cycle dump request, ignored while busy
//   core_addr1/2 decode-stage read addresses
//   REG_address1/2 read addresses driven to REG
//   data_out_1/2 combinational read data from REG
//   dump         stream master (dump_valid/dump_ready/dump_addr/dump_data)
//   busy         high from the cycle after start until DONE is exited
//   done         one-cycle pulse in the DONE state
//
// Build option: define REG_DUMP_SKIP_ZERO_EN to suppress beats whose captured
// value is zero (each skipped register still costs one cycle).
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int unsigned NUM_REGS = REG_COUNT,
  parameter int unsigned ADDR_W   = REG_ADDR_W,
  parameter int unsigned DATA_W   = REG_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        core_addr1,
  input  logic [ADDR_W-1:0]        core_addr2,
  output logic [ADDR_W-1:0]        REG_address1,
  output logic [ADDR_W-1:0]        REG_address2,
  input  logic [DATA_W-1:0]        data_out_1,
  input  logic [DATA_W-1:0]        data_out_2,
  reg_dump_reader_if.master        dump,
  output logic                     busy,
  output logic                     done
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_REGS - 2);

  dump_state_e       state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_hi;
  logic [DATA_W-1:0] cap_a;
  logic [DATA_W-1:0] cap_b;
  logic              hs;
  logic              keep_rd1;
  logic              keep_cap_b;
  logic              skip_a;
  logic              skip_b;

  assign ptr_hi = ptr + ADDR_W'(1);
  assign hs     = dump.dump_valid && dump.dump_ready;

  // Beat data comes straight from the capture registers, so it cannot change
  // while a beat waits for the consumer.
  assign dump.dump_data = (state == SEND_B) ? cap_b : cap_a;

  // keep_*: whether the beat about to be presented is emitted.
  // skip_*: advance without a handshake when the beat was suppressed.
  always_comb begin
`ifdef REG_DUMP_SKIP_ZERO_EN
    keep_rd1   = (data_out_1 != '0);
    keep_cap_b = (cap_b != '0);
    skip_a     = (cap_a == '0);
    skip_b     = (cap_b == '0);
`else
    keep_rd1   = 1'b1;
    keep_cap_b = 1'b1;
    skip_a     = 1'b0;
    skip_b     = 1'b0;
`endif
  end

  always_comb begin
    if (state == IDLE) begin
      REG_address1 = core_addr1;
      REG_address2 = core_addr2;
    end else begin
      REG_address1 = ptr;
      REG_address2 = ptr_hi;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      ptr            <= '0;
      cap_a          <= '0;
      cap_b          <= '0;
      dump.dump_valid <= 1'b0;
      dump.dump_addr  <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= READ;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        READ: begin
          cap_a           <= data_out_1;
          cap_b           <= data_out_2;
          dump.dump_valid <= keep_rd1;
          dump.dump_addr  <= ptr;
          state           <= SEND_A;
        end
        SEND_A: begin
          if (hs || skip_a) begin
            dump.dump_valid <= keep_cap_b;
            dump.dump_addr  <= ptr_hi;
            state           <= SEND_B;
          end
        end
        SEND_B: begin
          if (hs || skip_b) begin
            dump.dump_valid <= 1'b0;
            if (ptr == LAST_PTR) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              ptr   <= ptr + ADDR_W'(2);
              state <= READ;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
module tb_reg_dump_reader;
  import reg_dump_reader_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  core_addr1, core_addr2;
  logic [4:0]  REG_address1, REG_address2;
  logic [31:0] data_out_1, data_out_2;
  logic        busy, done;
  logic [31:0] regs [32];

  reg_dump_reader_if dump_if ();

  reg_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .core_addr1   (core_addr1),
    .core_addr2   (core_addr2),
    .REG_address1 (REG_address1),
    .REG_address2 (REG_address2),
    .data_out_1   (data_out_1),
    .data_out_2   (data_out_2),
    .dump         (dump_if),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  assign data_out_1 = regs[REG_address1];
  assign data_out_2 = regs[REG_address2];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  always @(posedge clk) cyc++;

  // Expected beat sequence
  int          exp_n;
  logic [4:0]  exp_addr [32];
  logic [31:0] exp_data [32];

  // Monitor state
  bit          mon_en = 1'b0;
  int          nbeats;
  logic [4:0]  beat_addr [64];
  logic [31:0] beat_data [64];
  int          done_cnt, done_cyc, first_valid_cyc;
  logic        busy_at_done, busy_after;
  bit          stall_prev = 1'b0;
  logic [4:0]  stall_addr;
  logic [31:0] stall_data;

  always @(negedge clk) begin
    if (mon_en) begin
      if (stall_prev) begin
        total_cnt++;
        if (dump_if.dump_valid !== 1'b1 || dump_if.dump_addr !== stall_addr ||
            dump_if.dump_data !== stall_data)
          $display("FAIL stall_hold: got v=%b a=%0d d=%h, want v=1 a=%0d d=%h",
                   dump_if.dump_valid, dump_if.dump_addr, dump_if.dump_data,
                   stall_addr, stall_data);
        else pass_cnt++;
      end
      stall_prev = (dump_if.dump_valid === 1'b1) && (dump_if.dump_ready === 1'b0);
      stall_addr = dump_if.dump_addr;
      stall_data = dump_if.dump_data;
      if (dump_if.dump_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (dump_if.dump_valid === 1'b1 && dump_if.dump_ready === 1'b1 && nbeats < 64) begin
        beat_addr[nbeats] = dump_if.dump_addr;
        beat_data[nbeats] = dump_if.dump_data;
        nbeats++;
      end
      if (done_cnt > 0 && cyc == done_cyc + 1) busy_after = busy;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc     = cyc;
        busy_at_done = busy;
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  function automatic logic [31:0] ref_val(input int a);
    case (a)
      1:       return 32'hDEADBEEF;
      2:       return 32'hCAFEBABE;
      3:       return 32'h12345678;
      15:      return 32'h9ABC9ABC;
      default: return 32'h0;
    endcase
  endfunction

  // Caller is always at posedge+1. mode 1 = ready pattern 1,0,0,1.
  task automatic run_dump(input int mode, input int restart_at, output int start_c);
    logic [3:0] pat;
    pat             = 4'b1001;
    nbeats          = 0;
    done_cnt        = 0;
    done_cyc        = -10;
    first_valid_cyc = -1;
    busy_at_done    = 1'bx;
    busy_after      = 1'bx;
    dump_if.dump_ready = 1'b1;
    mon_en  = 1'b1;
    start   = 1'b1;
    start_c = cyc;
    for (int k = 1; k < 400; k++) begin
      @(posedge clk); #1;
      start = (restart_at > 0 && k == restart_at) ? 1'b1 : 1'b0;
      if (mode == 1) dump_if.dump_ready = pat[k % 4];
      if (done_cnt > 0 && cyc >= done_cyc + 2) break;
    end
    start  = 1'b0;
    mon_en = 1'b0;
    dump_if.dump_ready = 1'b1;
    total_cnt++;
    if (done_cnt == 0) $display("FAIL dump_timeout: got no done pulse, want one within 400 cycles");
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; core_addr1 = 5'd3; core_addr2 = 5'd15;
    dump_if.dump_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({dump_if.dump_valid, busy, done} !== 3'b000)
      $display("FAIL reset_flags: got v/busy/done=%b%b%b want 000", dump_if.dump_valid, busy, done);
    else pass_cnt++;
    total_cnt++;
    if (dump_if.dump_addr !== 5'd0 || dump_if.dump_data !== 32'h0)
      $display("FAIL reset_beat: got a=%0d d=%h want a=0 d=0", dump_if.dump_addr, dump_if.dump_data);
    else pass_cnt++;
    total_cnt++;
    if (REG_address1 !== 5'd3 || REG_address2 !== 5'd15)
      $display("FAIL reset_addr: got %0d/%0d want 3/15", REG_address1, REG_address2);
    else pass_cnt++;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_passthrough();
    core_addr1 = 5'd3; core_addr2 = 5'd15;
    @(posedge clk); #1;
    total_cnt++;
    if (REG_address1 !== 5'd3 || REG_address2 !== 5'd15)
      $display("FAIL pass_addr: got %0d/%0d want 3/15", REG_address1, REG_address2);
    else pass_cnt++;
    total_cnt++;
    if (data_out_1 !== 32'h12345678 || data_out_2 !== 32'h9ABC9ABC)
      $display("FAIL pass_data: got %h/%h want 12345678/9abc9abc", data_out_1, data_out_2);
    else pass_cnt++;
    core_addr1 = 5'd1; core_addr2 = 5'd2;
    #1;
    total_cnt++;
    if (REG_address1 !== 5'd1 || REG_address2 !== 5'd2 || busy !== 1'b0)
      $display("FAIL pass_follow: got %0d/%0d busy=%b want 1/2 busy=0", REG_address1, REG_address2, busy);
    else pass_cnt++;
  endtask

  task automatic test_full_dump();
    int sc;
    int fv;
`ifdef REG_DUMP_SKIP_ZERO_EN
    fv = 3;
`else
    fv = 2;
`endif
    run_dump(0, 0, sc);
    total_cnt++;
    if (nbeats !== exp_n) $display("FAIL full_count: got %0d want %0d", nbeats, exp_n);
    else pass_cnt++;
    for (int i = 0; i < exp_n && i < nbeats; i++) begin
      total_cnt++;
      if (beat_addr[i] !== exp_addr[i] || beat_data[i] !== exp_data[i])
        $display("FAIL full_beat%0d: got a=%0d d=%h want a=%0d d=%h",
                 i, beat_addr[i], beat_data[i], exp_addr[i], exp_data[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (done_cnt !== 1 || done_cyc - sc !== 49)
      $display("FAIL full_done: got %0d pulses at +%0d want 1 at +49", done_cnt, done_cyc - sc);
    else pass_cnt++;
    total_cnt++;
    if (busy_at_done !== 1'b1 || busy_after !== 1'b0)
      $display("FAIL full_busy: got done/next busy=%b/%b want 1/0", busy_at_done, busy_after);
    else pass_cnt++;
    total_cnt++;
    if (first_valid_cyc - sc !== fv)
      $display("FAIL full_first_valid: got +%0d want +%0d", first_valid_cyc - sc, fv);
    else pass_cnt++;
  endtask

  task automatic test_ready_pattern();
    int sc;
    run_dump(1, 0, sc);
    total_cnt++;
    if (nbeats !== exp_n) $display("FAIL pat_count: got %0d want %0d", nbeats, exp_n);
    else pass_cnt++;
    for (int i = 0; i < exp_n && i < nbeats; i++) begin
      total_cnt++;
      if (beat_addr[i] !== exp_addr[i] || beat_data[i] !== exp_data[i])
        $display("FAIL pat_beat%0d: got a=%0d d=%h want a=%0d d=%h",
                 i, beat_addr[i], beat_data[i], exp_addr[i], exp_data[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (done_cnt !== 1) $display("FAIL pat_done: got %0d pulses want 1", done_cnt);
    else pass_cnt++;
  endtask

  task automatic test_start_while_busy();
    int sc;
    // Cycle 17 is SEND_A of pair (10,11): beat 10 is on the stream.
    run_dump(0, 17, sc);
    total_cnt++;
    if (nbeats !== exp_n) $display("FAIL busy_start_count: got %0d want %0d", nbeats, exp_n);
    else pass_cnt++;
    for (int i = 0; i < exp_n && i < nbeats; i++) begin
      total_cnt++;
      if (beat_addr[i] !== exp_addr[i] || beat_data[i] !== exp_data[i])
        $display("FAIL busy_start_beat%0d: got a=%0d d=%h want a=%0d d=%h",
                 i, beat_addr[i], beat_data[i], exp_addr[i], exp_data[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (done_cnt !== 1 || done_cyc - sc !== 49)
      $display("FAIL busy_start_done: got %0d pulses at +%0d want 1 at +49", done_cnt, done_cyc - sc);
    else pass_cnt++;
  endtask

  task automatic test_start_at_done();
    bit seen;
    seen  = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (done === 1'b1) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    total_cnt++;
    if (!seen) $display("FAIL done_start_wait: got no done pulse, want one within 200 cycles");
    else pass_cnt++;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (busy !== 1'b0 || dump_if.dump_valid !== 1'b0 || done !== 1'b0)
      $display("FAIL done_start_ignored: got busy/v/done=%b%b%b want 000", busy, dump_if.dump_valid, done);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int   sc;
    logic exp_v;
`ifdef REG_DUMP_SKIP_ZERO_EN
    exp_v = 1'b0;
`else
    exp_v = 1'b1;
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    // Now in SEND_B of pair (6,7).
    total_cnt++;
    if (dump_if.dump_addr !== 5'd7 || dump_if.dump_valid !== exp_v ||
        REG_address1 !== 5'd6 || REG_address2 !== 5'd7)
      $display("FAIL mid_pos: got a=%0d v=%b ra=%0d/%0d want a=7 v=%b ra=6/7",
               dump_if.dump_addr, dump_if.dump_valid, REG_address1, REG_address2, exp_v);
    else pass_cnt++;
    core_addr1 = 5'd3; core_addr2 = 5'd15;
    reset = 1'b0;
    #1;
    total_cnt++;
    if ({dump_if.dump_valid, busy, done} !== 3'b000 || REG_address1 !== 5'd3 || REG_address2 !== 5'd15)
      $display("FAIL mid_abort: got v/busy/done=%b%b%b ra=%0d/%0d want 000 ra=3/15",
               dump_if.dump_valid, busy, done, REG_address1, REG_address2);
    else pass_cnt++;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0 || REG_address1 !== 5'd3)
      $display("FAIL mid_release: got busy=%b done=%b ra1=%0d want 0/0/3", busy, done, REG_address1);
    else pass_cnt++;
    run_dump(0, 0, sc);
    total_cnt++;
    if (nbeats !== exp_n || beat_addr[0] !== exp_addr[0] || beat_data[0] !== exp_data[0])
      $display("FAIL mid_redump: got n=%0d a0=%0d d0=%h want n=%0d a0=%0d d0=%h",
               nbeats, beat_addr[0], beat_data[0], exp_n, exp_addr[0], exp_data[0]);
    else pass_cnt++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = ref_val(i);
    exp_n = 0;
    for (int a = 0; a < 32; a++) begin
`ifdef REG_DUMP_SKIP_ZERO_EN
      if (ref_val(a) != 32'h0) begin
`else
      begin
`endif
        exp_addr[exp_n] = 5'(a);
        exp_data[exp_n] = ref_val(a);
        exp_n++;
      end
    end

    test_reset();
    test_passthrough();
    test_full_dump();
    test_ready_pattern();
    test_start_while_busy();
    test_start_at_done();
    test_reset_mid();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
- Debug/verification reader for the 32x32 register file (REG). On `start` it walks every register through REG's two combinational read ports, two registers per pass.
- It emits one (address, data) beat per register on a valid/ready stream toward the debug/trace path.
- While idle, the core's own read addresses pass straight through to REG, so the block sits between the decode stage and REG's read-address inputs.

Parameters:
- NUM_REGS, 32, number of registers walked; must be even and ≥2.
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a dump; ignored while busy.
- core_addr1  in  ADDR_W  decode-stage read address, port 1.
- core_addr2  in  ADDR_W  decode-stage read address, port 2.
- REG_address1  out  ADDR_W  to REG read port 1.
- REG_address2  out  ADDR_W  to REG read port 2.
- data_out_1  in  DATA_W  from REG read port 1 (combinational).
- data_out_2  in  DATA_W  from REG read port 2 (combinational).
- dump_valid  out  1  beat valid.
- dump_ready  in  1  consumer ready.
- dump_addr  out  ADDR_W  register index of the current beat.
- dump_data  out  DATA_W  register contents of the current beat.
- busy  out  1  high from the cycle after start until DONE is exited.
- done  out  1  one-cycle pulse in the DONE state.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, ptr=0; dump_valid, dump_addr, dump_data, busy, done and both capture registers = 0.
- Address mux (combinational):
  - IDLE: REG_address1/2 = core_addr1/2.
  - READ: REG_address1 = ptr, REG_address2 = ptr+1.
  - All other states: REG_address1/2 hold ptr / ptr+1.
- IDLE: start=1 → READ, ptr=0, busy=1 next cycle.
- READ (one cycle): at the clock edge, cap_a←data_out_1 and cap_b←data_out_2; → SEND_A.
- SEND_A: dump_valid=1, dump_addr=ptr, dump_data=cap_a.
  - On dump_valid&&dump_ready → SEND_B.
- SEND_B: dump_valid=1, dump_addr=ptr+1, dump_data=cap_b.
  - On handshake: if ptr+2==NUM_REGS → DONE; else ptr+=2 and → READ.
- DONE: done=1 for one cycle, dump_valid=0 → IDLE; busy drops in the following cycle.
- Handshake rules:
  - Once dump_valid is asserted, dump_addr and dump_data are stable until the handshake.
  - dump_ready may be held low indefinitely; the block stalls without re-reading REG.
- Latency: with dump_ready tied high, a full dump takes 3 cycles per pair, i.e. 48 cycles plus 1 DONE cycle for NUM_REGS=32. The first beat is valid 2 cycles after start.
- Boundary conditions:
  - Register 0 is dumped like any other register, expected value 0.
  - ptr never exceeds NUM_REGS-2; no wrap-around.
  - start asserted while busy has no effect.
  - start in the same cycle as DONE is ignored.
  - Reset mid-dump aborts immediately to IDLE with outputs cleared; no done pulse.
- Snapshot coherence: the block does not block REG writes. Data is captured per pair in READ, so a write landing after a pair's READ cycle is not reflected in that pair.

Optional Feature:
- Macro: REG_DUMP_SKIP_ZERO_EN.
- Defined: in SEND_A/SEND_B, if the captured value is 0, dump_valid stays 0 and the state advances immediately, one cycle per skipped register, exactly as if a handshake had occurred. done is still pulsed even if zero beats were emitted.
- Undefined: all NUM_REGS beats are always emitted.

Decomposition:
- Shared package (datapath pkg): ADDR_W/DATA_W constants (shared with REG) and the dump FSM state enum {IDLE, READ, SEND_A, SEND_B, DONE}.
- No sub-module needed. The address mux and two capture registers stay inline; one FSM plus a pointer counter is the natural structure.

Test Plan:
- Preload REG: r1=DEADBEEF, r2=CAFEBABE, r3=12345678, r15=9ABC9ABC, rest 0. Pulse start, dump_ready=1 → 32 beats in address order 0..31 with matching data (r0=0, r1=DEADBEEF, …). done pulses at cycle 49 after start; busy falls the next cycle.
- Same preload, dump_ready toggled 1-0-0-1 pattern → beat sequence unchanged, dump_addr/dump_data stable while valid&&!ready, no beats lost or duplicated.
- Idle pass-through: busy=0, core_addr1=3, core_addr2=15 → REG_address1=3, REG_address2=15, and data_out reflects 12345678 / 9ABC9ABC.
- start pulsed again at beat 10 → ignored; exactly 32 beats and one done pulse.
- Assert reset=0 during SEND_B of pair (6,7) → dump_valid=0, busy=0 and REG_address follows core_addr on release; a new start dumps from r0 again.
- With REG_DUMP_SKIP_ZERO_EN and the preload above → exactly 4 beats (1, 2, 3, 15) with correct data, then a done pulse.
